// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes and ALUOp encodings shared by the issue stage and aluOps
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - combinational ALUOp/funct decode to 4-bit ALU op
module alu_control
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] op,
  output logic       illegal
);

  always_comb begin
    op      = ALU_ILLEGAL;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM:    op = ALU_ADD;
      ALUOP_BRANCH: op = ALU_SUB;
      default: begin
        case (funct3)
          // funct7 bit 5 only selects SUB for register-register forms
          F3_ADD:  op = (aluop == ALUOP_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
          F3_AND:  op = ALU_AND;
          F3_OR:   op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - EX-stage issue front end: decode, operand select, forwarding, result tagging
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_b5,
  input  logic              in_alusrc,
  input  logic [REG_AW-1:0] in_rs1_idx,
  input  logic [REG_AW-1:0] in_rs2_idx,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  output logic              alu_enable,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              out_illegal
);

  logic [3:0]        dec_op;
  logic              dec_illegal;
  logic [DATA_W-1:0] imm_ext;

  logic              e1_v, e1_illegal, e1_alusrc, e1_regwrite;
  logic [3:0]        e1_op;
  logic [REG_AW-1:0] e1_rs1_idx, e1_rs2_idx, e1_rd;
  logic [DATA_W-1:0] e1_rs1_data, e1_op2;

  logic              e2_v, e2_regwrite, e2_illegal;
  logic [REG_AW-1:0] e2_rd;

  logic              w_v, w_regwrite;
  logic [REG_AW-1:0] w_rd;
  logic [DATA_W-1:0] w_result;

  logic              advance, accept, retire;
  logic              e2_hit1, e2_hit2, w_hit1, w_hit2;
  logic [DATA_W-1:0] opnd1, opnd2;

  alu_control u_alu_control (
    .aluop     (in_aluop),
    .funct3    (in_funct3),
    .funct7_b5 (in_funct7_b5),
    .op        (dec_op),
    .illegal   (dec_illegal)
  );

  assign imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  assign advance  = e1_v && (!e2_v || out_ready);
  assign in_ready = !e1_v || advance;
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = e2_v && out_ready;

  // E2's result is the live ALU output; W holds the most recently retired write
  assign e2_hit1 = e2_v && e2_regwrite && (e1_rs1_idx != '0) && (e2_rd == e1_rs1_idx);
  assign w_hit1  = w_v && w_regwrite && (e1_rs1_idx != '0) && (w_rd == e1_rs1_idx);
  assign e2_hit2 = e2_v && e2_regwrite && (e1_rs2_idx != '0) && (e2_rd == e1_rs2_idx);
  assign w_hit2  = w_v && w_regwrite && (e1_rs2_idx != '0) && (w_rd == e1_rs2_idx);

  always_comb begin
    opnd1 = e1_rs1_data;
    if (e2_hit1)     opnd1 = alu_result;
    else if (w_hit1) opnd1 = w_result;
    opnd2 = e1_op2;
    if (!e1_alusrc) begin
      if (e2_hit2)     opnd2 = alu_result;
      else if (w_hit2) opnd2 = w_result;
    end
  end

  assign alu_enable   = advance;
  assign alu_op       = e1_v ? e1_op : ALU_ILLEGAL;
  assign alu_data1    = e1_v ? opnd1 : '0;
  assign alu_data2    = e1_v ? opnd2 : '0;

  assign out_valid    = e2_v;
  assign out_result   = alu_result;
  assign out_zero     = alu_zero;
  assign out_rd       = e2_rd;
  assign out_regwrite = e2_regwrite;
  assign out_illegal  = e2_illegal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e1_v        <= 1'b0;
      e1_op       <= ALU_ILLEGAL;
      e1_illegal  <= 1'b0;
      e1_alusrc   <= 1'b0;
      e1_regwrite <= 1'b0;
      e1_rs1_idx  <= '0;
      e1_rs2_idx  <= '0;
      e1_rd       <= '0;
      e1_rs1_data <= '0;
      e1_op2      <= '0;
      e2_v        <= 1'b0;
      e2_regwrite <= 1'b0;
      e2_illegal  <= 1'b0;
      e2_rd       <= '0;
      w_v         <= 1'b0;
      w_regwrite  <= 1'b0;
      w_rd        <= '0;
      w_result    <= '0;
    end else begin
      if (flush) begin
        e1_v <= 1'b0;
      end else if (accept) begin
        e1_v        <= 1'b1;
        e1_op       <= dec_op;
        e1_illegal  <= dec_illegal;
        e1_alusrc   <= in_alusrc;
        e1_regwrite <= in_regwrite;
        e1_rs1_idx  <= in_rs1_idx;
        e1_rs2_idx  <= in_rs2_idx;
        e1_rd       <= in_rd;
        e1_rs1_data <= in_rs1_data;
        e1_op2      <= in_alusrc ? imm_ext : in_rs2_data;
      end else if (advance) begin
        e1_v <= 1'b0;
      end

      if (flush) begin
        e2_v <= 1'b0;
      end else if (advance) begin
        e2_v        <= 1'b1;
        e2_rd       <= e1_rd;
        e2_regwrite <= e1_regwrite;
        e2_illegal  <= e1_illegal;
      end else if (retire) begin
        e2_v <= 1'b0;
      end

      if (flush) begin
        w_v <= 1'b0;
      end else if (retire) begin
        w_v        <= 1'b1;
        w_rd       <= e2_rd;
        w_regwrite <= e2_regwrite;
        w_result   <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a registered ALU model
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_aluop = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7_b5 = 1'b0;
  logic        in_alusrc = 1'b0;
  logic [4:0]  in_rs1_idx = '0, in_rs2_idx = '0, in_rd = '0;
  logic [63:0] in_rs1_data = '0, in_rs2_data = '0;
  logic [11:0] in_imm = '0;
  logic        in_regwrite = 1'b0;
  logic        alu_enable;
  logic [3:0]  alu_op;
  logic [63:0] alu_data1, alu_data2;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_illegal;

  typedef struct {
    logic [63:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        regwrite;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] commit[32];
  logic [63:0] arch[32];
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clock = ~clock;

  alu_issue_stage dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
    .in_alusrc(in_alusrc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rd(in_rd), .in_regwrite(in_regwrite),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_rd(out_rd), .out_regwrite(out_regwrite), .out_illegal(out_illegal)
  );

  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_op(input logic [1:0] a, input logic [2:0] f, input logic b5);
    if (a == 2'b00) return 4'b0010;
    if (a == 2'b01) return 4'b0110;
    if (f == 3'b000) return (a == 2'b10 && b5) ? 4'b0110 : 4'b0010;
    if (f == 3'b111) return 4'b0000;
    if (f == 3'b110) return 4'b0001;
    return 4'b1111;
  endfunction

  function automatic logic [63:0] init_val(input int i);
    case (i)
      0:       return 64'd0;
      3:       return 64'h33;
      5:       return 64'hF;
      6:       return 64'd3;
      10:      return 64'd5;
      11:      return 64'd7;
      12:      return 64'd1;
      14:      return 64'd4;
      default: return 64'h100 + 64'(i);
    endcase
  endfunction

  // Registered ALU (aluOps) seen by the stage
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_result <= '0;
      alu_zero   <= 1'b0;
    end else if (alu_enable) begin
      alu_result <= alu_fn(alu_op, alu_data1, alu_data2);
      alu_zero   <= (alu_fn(alu_op, alu_data1, alu_data2) == 64'd0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_in_ready"}, in_ready, 1);
    chk({p, "_out_valid"}, out_valid, 0);
    chk({p, "_alu_enable"}, alu_enable, 0);
    chk({p, "_alu_op"}, alu_op, 4'hF);
    chk({p, "_alu_data1"}, alu_data1, 0);
    chk({p, "_alu_data2"}, alu_data2, 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Retire monitor: pops the scoreboard and commits to the register-file model
  initial begin
    exp_t e;
    for (int i = 0; i < 32; i++) commit[i] = init_val(i);
    forever begin
      @(negedge clock);
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("result", out_result, e.result);
          chk("zero", out_zero, e.zero);
          chk("rd", out_rd, e.rd);
          chk("regwrite", out_regwrite, e.regwrite);
          chk("illegal", out_illegal, e.illegal);
          if (e.regwrite && e.rd != 0) commit[e.rd] = e.result;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic b5,
                       input logic src, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [11:0] imm, input logic [4:0] rd, input logic rw);
    exp_t        e;
    logic [63:0] a, b;
    logic [3:0]  op;
    int          tries;
    bit          ok;
    in_valid = 1'b1; in_aluop = aop; in_funct3 = f3; in_funct7_b5 = b5;
    in_alusrc = src; in_rs1_idx = rs1; in_rs2_idx = rs2; in_imm = imm;
    in_rd = rd; in_regwrite = rw;
    tries = 0;
    ok = 1'b0;
    while (!ok && tries < 40) begin
      in_rs1_data = commit[rs1];
      in_rs2_data = commit[rs2];
      @(negedge clock);
      if (in_ready) ok = 1'b1;
      else begin
        tries++;
        cyc(1);
        if (tries > 4) out_ready = 1'b1;
      end
    end
    if (!ok) begin
      chk("accept_timeout", in_ready, 1);
    end else begin
      op = ref_op(aop, f3, b5);
      a  = arch[rs1];
      b  = src ? {{52{imm[11]}}, imm} : arch[rs2];
      e.result   = alu_fn(op, a, b);
      e.zero     = (e.result == 64'd0);
      e.rd       = rd;
      e.regwrite = rw;
      e.illegal  = (op == 4'b1111);
      sb.push_back(e);
      if (rw && rd != 0) arch[rd] = e.result;
    end
    cyc(1);
    in_valid = 1'b0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 32; i++) arch[i] = init_val(i);
    #1;
    chk_rst("reset");
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // single R-type ADD 5+7
    issue(2'b10, 3'b000, 1'b0, 1'b0, 5'd10, 5'd11, 12'd0, 5'd13, 1'b1);
    chk("t1_alu_op", alu_op, 4'b0010);
    chk("t1_alu_enable", alu_enable, 1);
    chk("t1_out_valid_early", out_valid, 0);
    cyc(1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_result", out_result, 64'd12);
    cyc(2);

    // back-to-back dependency through E2
    issue(2'b10, 3'b000, 1'b0, 1'b0, 5'd6, 5'd14, 12'd0, 5'd1, 1'b1);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd12, 12'd0, 5'd2, 1'b1);
    chk("b2b_fwd_e2", alu_data1, 64'd7);
    cyc(3);

    // dependency two back through W
    issue(2'b11, 3'b000, 1'b0, 1'b1, 5'd0, 5'd0, 12'd10, 5'd3, 1'b1);
    issue(2'b10, 3'b111, 1'b0, 1'b0, 5'd5, 5'd6, 12'd0, 5'd4, 1'b1);
    issue(2'b11, 3'b110, 1'b0, 1'b1, 5'd3, 5'd0, 12'h020, 5'd7, 1'b1);
    chk("w_fwd", alu_data1, 64'd10);
    cyc(3);

    // downstream stall with two queued
    out_ready = 1'b0;
    issue(2'b10, 3'b000, 1'b0, 1'b0, 5'd10, 5'd11, 12'd0, 5'd8, 1'b1);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 5'd8, 5'd12, 12'd0, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_alu_enable", alu_enable, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_result", out_result, 64'd12);
      cyc(1);
    end
    out_ready = 1'b1;
    cyc(3);
    chk("stall_drain", sb.size(), 0);

    // illegal decode and immediate wrap to zero
    issue(2'b10, 3'b001, 1'b0, 1'b0, 5'd10, 5'd11, 12'd0, 5'd9, 1'b1);
    chk("illegal_alu_op", alu_op, 4'hF);
    issue(2'b11, 3'b000, 1'b1, 1'b1, 5'd12, 5'd0, 12'hFFF, 5'd15, 1'b1);
    cyc(3);

    // flush with E1 and E2 full, plus a dropped simultaneous request
    out_ready = 1'b0;
    issue(2'b10, 3'b000, 1'b0, 1'b0, 5'd10, 5'd11, 12'd0, 5'd16, 1'b1);
    issue(2'b10, 3'b110, 1'b0, 1'b0, 5'd10, 5'd11, 12'd0, 5'd17, 1'b1);
    flush = 1'b1;
    in_valid = 1'b1;
    cyc(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_alu_op", alu_op, 4'hF);
    chk("flush_in_ready", in_ready, 1);
    sb.delete();
    for (int i = 0; i < 32; i++) arch[i] = commit[i];
    out_ready = 1'b1;
    cyc(2);
    chk("flush_stays_empty", out_valid, 0);

    // asynchronous reset mid-stream
    issue(2'b10, 3'b000, 1'b0, 1'b0, 5'd10, 5'd11, 12'd0, 5'd18, 1'b1);
    issue(2'b10, 3'b000, 1'b0, 1'b0, 5'd10, 5'd10, 12'd0, 5'd19, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_rst("midreset");
    sb.delete();
    for (int i = 0; i < 32; i++) arch[i] = commit[i];
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // random traffic with random back-pressure
    for (int n = 0; n < 60; n++) begin
      logic [1:0] aop;
      logic [2:0] f3;
      logic       src;
      aop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: f3 = 3'b000;
        1: f3 = 3'b111;
        2: f3 = 3'b110;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      src = (aop == 2'b11) ? 1'b1 : (aop == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      issue(aop, f3, 1'($urandom_range(0, 1)), src, 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)),
            5'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 4) == 0) cyc(1);
    end
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      cyc(1);
      guard++;
    end
    chk("final_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
